processor_sequencer: RTL and testbench

PROCESSOR_SEQUENCER -- requirements
Module: processor_sequencer

---
 rtl/processor_pkg.sv | 56 +++++
 rtl/processor_decode.sv | 58 +++++
 rtl/processor_sequencer.sv | 141 ++++++++++++++
 tb/tb_processor_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the instruction sequencer: state encodings,
// opcode class bytes, top-nibble classes and the per-state enable bundles.
package processor_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcode class bytes (opcode[DATA_WIDTH-1 -: 8])
  localparam logic [7:0] CLS_ALU_RD      = 8'h22;
  localparam logic [7:0] CLS_RAM_RD      = 8'h42;
  localparam logic [7:0] CLS_RAM_WR      = 8'h41;
  localparam logic [7:0] CLS_ROM_TO_RAM  = 8'h31;
  localparam logic [7:0] CLS_RAM_TO_ALU  = 8'h92;
  localparam logic [7:0] CLS_ALU_TO_RAM  = 8'h91;
  localparam logic [7:0] CLS_RAM_ROM_RAM = 8'h32;

  // Top-nibble classes (opcode[DATA_WIDTH-1 -: 4])
  localparam logic [3:0] NIB_ALU  = 4'h1;
  localparam logic [3:0] NIB_LOAD = 4'h7;
  localparam logic [3:0] NIB_NOP  = 4'hF;

  typedef struct packed {
    logic pc_read_en;
    logic rom_en;
    logic rom_data_en;
    logic ram_rd_en;
    logic ram_wr_en;
    logic alu_rd_en;
    logic alu_wr_en;
    logic pc_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE  = ctrl_t'(8'h00);
  localparam ctrl_t CTRL_FETCH = ctrl_t'(8'hC0);

  function automatic ctrl_t exec_ctrl(input logic [3:0] nib);
    ctrl_t c;
    c           = CTRL_NONE;
    c.alu_wr_en = (nib == NIB_ALU);
    return c;
  endfunction

  function automatic ctrl_t commit_ctrl(input logic [3:0] nib);
    ctrl_t c;
    c           = CTRL_NONE;
    c.pc_en     = 1'b1;
    c.ram_rd_en = (nib == NIB_LOAD);
    return c;
  endfunction

endpackage

// File: rtl/processor_decode.sv
// Combinational opcode decoder: maps the class byte to DECODE-phase enables and
// flags memory classes, data-load classes, the all-zero HALT opcode and illegal codes.
module processor_decode
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_opcode,
  output ctrl_t                 o_ctrl,
  output logic                  o_mem_class,
  output logic                  o_load_class,
  output logic                  o_zero,
  output logic                  o_illegal
);

  logic [7:0] w_class;
  logic [3:0] w_nib;
  logic       w_listed;

  assign w_class = i_opcode[DATA_WIDTH-1 -: 8];
  assign w_nib   = i_opcode[DATA_WIDTH-1 -: 4];

  always_comb begin
    o_ctrl   = CTRL_NONE;
    w_listed = 1'b1;
    case (w_class)
      CLS_ALU_RD: o_ctrl.alu_rd_en = 1'b1;
      CLS_RAM_RD: o_ctrl.ram_rd_en = 1'b1;
      CLS_RAM_WR: o_ctrl.ram_wr_en = 1'b1;
      CLS_ROM_TO_RAM: begin
        o_ctrl.rom_data_en = 1'b1;
        o_ctrl.ram_wr_en   = 1'b1;
      end
      CLS_RAM_TO_ALU: begin
        o_ctrl.ram_rd_en = 1'b1;
        o_ctrl.alu_wr_en = 1'b1;
      end
      CLS_ALU_TO_RAM: begin
        o_ctrl.alu_rd_en = 1'b1;
        o_ctrl.ram_wr_en = 1'b1;
      end
      CLS_RAM_ROM_RAM: begin
        o_ctrl.ram_rd_en   = 1'b1;
        o_ctrl.rom_data_en = 1'b1;
        o_ctrl.ram_wr_en   = 1'b1;
      end
      default: w_listed = 1'b0;
    endcase
  end

  // Any class that touches ROM/RAM must wait for mem_ready before leaving DECODE
  assign o_mem_class  = o_ctrl.rom_data_en | o_ctrl.ram_rd_en | o_ctrl.ram_wr_en;
  assign o_load_class = (w_class == CLS_ALU_RD) || (w_class == CLS_RAM_RD);
  assign o_zero       = (i_opcode == '0);
  assign o_illegal    = !o_zero && !w_listed &&
                        (w_nib != NIB_ALU) && (w_nib != NIB_LOAD) && (w_nib != NIB_NOP);

endmodule

// File: rtl/processor_sequencer.sv
// FETCH/DECODE/EXEC/COMMIT/HALT instruction sequencer with registered datapath enables.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input that gates leaving FETCH.
module processor_sequencer
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0] data_bus,
  input  logic                  mem_ready,
  input  logic                  resume,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  pc_read_en,
  output logic                  rom_en,
  output logic                  rom_data_en,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic                  alu_rd_en,
  output logic                  alu_wr_en,
  output logic                  pc_en,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  illegal,
  output logic [RETIRE_W-1:0]   retired
);

  state_t                r_state;
  ctrl_t                 r_ctrl;
  logic [DATA_WIDTH-1:0] r_data;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  r_illegal;
  logic                  r_halted;

  ctrl_t      w_dec_ctrl;
  logic       w_dec_mem;
  logic       w_dec_load;
  logic       w_dec_zero;
  logic       w_dec_illegal;
  logic       w_fetch_go;
  logic [3:0] w_nib;

  processor_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .i_opcode    (opcode),
    .o_ctrl      (w_dec_ctrl),
    .o_mem_class (w_dec_mem),
    .o_load_class(w_dec_load),
    .o_zero      (w_dec_zero),
    .o_illegal   (w_dec_illegal)
  );

  assign w_nib = opcode[DATA_WIDTH-1 -: 4];

`ifdef SEQ_SINGLE_STEP_EN
  assign w_fetch_go = mem_ready & step;
`else
  assign w_fetch_go = mem_ready;
`endif

  // Enables are registered: each transition loads the bundle of the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_ctrl    <= CTRL_FETCH;
      r_data    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_halted <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (w_fetch_go) begin
            r_state <= ST_DECODE;
            r_ctrl  <= w_dec_ctrl;
          end
        end
        ST_DECODE: begin
          if (w_dec_illegal) begin
            r_illegal <= 1'b1;
          end
          if (w_dec_zero) begin
            r_state  <= ST_HALT;
            r_ctrl   <= CTRL_NONE;
            r_halted <= 1'b1;
          end else if (!w_dec_mem || mem_ready) begin
            r_state <= ST_EXEC;
            r_ctrl  <= exec_ctrl(w_nib);
            if (w_dec_load) begin
              r_data <= data_bus;
            end
          end
        end
        ST_EXEC: begin
          r_state <= ST_COMMIT;
          r_ctrl  <= commit_ctrl(w_nib);
        end
        ST_COMMIT: begin
          r_state   <= ST_FETCH;
          r_ctrl    <= CTRL_FETCH;
          r_retired <= r_retired + RETIRE_W'(1);
        end
        ST_HALT: begin
          // Resuming goes through COMMIT so the PC steps past the halt opcode
          if (resume) begin
            r_state <= ST_COMMIT;
            r_ctrl  <= commit_ctrl(w_nib);
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FETCH;
          r_ctrl  <= CTRL_FETCH;
        end
      endcase
    end
  end

  assign pc_read_en  = r_ctrl.pc_read_en;
  assign rom_en      = r_ctrl.rom_en;
  assign rom_data_en = r_ctrl.rom_data_en;
  assign ram_rd_en   = r_ctrl.ram_rd_en;
  assign ram_wr_en   = r_ctrl.ram_wr_en;
  assign alu_rd_en   = r_ctrl.alu_rd_en;
  assign alu_wr_en   = r_ctrl.alu_wr_en;
  assign pc_en       = r_ctrl.pc_en;
  assign data_output = r_data;
  assign state       = r_state;
  assign halted      = r_halted;
  assign illegal     = r_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_processor_sequencer.sv
// Bench for processor_sequencer: per-instruction expected cycle traces built from the
// instruction rules, replayed against the DUT with every cycle compared.
module tb_processor_sequencer;

  localparam int DW = 16;
  localparam int RW = 4;

  localparam logic [7:0] E_PCR   = 8'h80;
  localparam logic [7:0] E_ROM   = 8'h40;
  localparam logic [7:0] E_ROMD  = 8'h20;
  localparam logic [7:0] E_RAMRD = 8'h10;
  localparam logic [7:0] E_RAMWR = 8'h08;
  localparam logic [7:0] E_ALURD = 8'h04;
  localparam logic [7:0] E_ALUWR = 8'h02;
  localparam logic [7:0] E_PCEN  = 8'h01;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] opcode, data_bus;
  logic          mem_ready, resume;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step;
`endif
  logic          pc_read_en, rom_en, rom_data_en, ram_rd_en, ram_wr_en;
  logic          alu_rd_en, alu_wr_en, pc_en;
  logic [DW-1:0] data_output;
  logic [2:0]    state;
  logic          halted, illegal;
  logic [RW-1:0] retired;

  processor_sequencer #(.DATA_WIDTH(DW), .RETIRE_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .data_bus   (data_bus),
    .mem_ready  (mem_ready),
    .resume     (resume),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .pc_read_en (pc_read_en),
    .rom_en     (rom_en),
    .rom_data_en(rom_data_en),
    .ram_rd_en  (ram_rd_en),
    .ram_wr_en  (ram_wr_en),
    .alu_rd_en  (alu_rd_en),
    .alu_wr_en  (alu_wr_en),
    .pc_en      (pc_en),
    .data_output(data_output),
    .state      (state),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] op;
    logic [DW-1:0] db;
    logic          mr;
    logic          rs;
    logic          stp;
    logic [2:0]    st;
    logic [7:0]    en;
    logic [DW-1:0] dout;
    logic          hlt;
    logic          ill;
    logic [RW-1:0] ret;
  } cyc_t;

  cyc_t          q[$];
  logic [DW-1:0] m_dout;
  logic          m_ill, m_hlt;
  logic [RW-1:0] m_ret;

  int            n_chk = 0;
  int            n_pass = 0;
  int            n_instr = 0;
  logic [31:0]   o_states;
  int            o_ramrd, o_aluwr, o_pcen, o_hlt, o_pre;

  function automatic logic [7:0] dut_en();
    return {pc_read_en, rom_en, rom_data_en, ram_rd_en, ram_wr_en, alu_rd_en, alu_wr_en, pc_en};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Enables a class byte must raise while in DECODE
  function automatic logic [7:0] class_en(input logic [7:0] cls);
    case (cls)
      8'h22:   return E_ALURD;
      8'h42:   return E_RAMRD;
      8'h41:   return E_RAMWR;
      8'h31:   return E_ROMD | E_RAMWR;
      8'h92:   return E_RAMRD | E_ALUWR;
      8'h91:   return E_ALURD | E_RAMWR;
      8'h32:   return E_RAMRD | E_ROMD | E_RAMWR;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push(input logic [DW-1:0] op, input logic [DW-1:0] db, input logic mr,
                      input logic rs, input logic stp, input logic [2:0] st, input logic [7:0] en);
    cyc_t c;
    c.op = op; c.db = db; c.mr = mr; c.rs = rs; c.stp = stp; c.st = st; c.en = en;
    c.dout = m_dout; c.hlt = m_hlt; c.ill = m_ill; c.ret = m_ret;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle trace of one instruction; model registers update between cycles
  task automatic build(input logic [DW-1:0] op, input logic [DW-1:0] d, input int fs,
                       input int ds, input int hw);
    logic [7:0] cls, den;
    logic [3:0] nib;
    logic       mem, listed, is_ill, is_load, smr, sst;
    int         p;
    cls     = op[DW-1 -: 8];
    nib     = op[DW-1 -: 4];
    den     = class_en(cls);
    mem     = |(den & (E_ROMD | E_RAMRD | E_RAMWR));
    listed  = cls inside {8'h22, 8'h42, 8'h41, 8'h31, 8'h92, 8'h91, 8'h32};
    is_ill  = (op != '0) && !listed && !(nib inside {4'h1, 4'h7, 4'hF});
    is_load = (cls == 8'h22) || (cls == 8'h42);
    q.delete();
    for (int i = 0; i < fs; i++) begin
`ifdef SEQ_SINGLE_STEP_EN
      p   = $urandom_range(0, 2);
      smr = (p == 1);
      sst = (p == 0);
`else
      p   = 0;
      smr = 1'b0;
      sst = 1'($urandom_range(0, 1));
`endif
      push(op, 16'($urandom), smr, 1'($urandom_range(0, 1)), sst, 3'd0, E_PCR | E_ROM);
    end
    push(op, 16'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b1, 3'd0, E_PCR | E_ROM);
    if (op == '0) begin
      push(op, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'd1, 8'h00);
      m_hlt = 1'b1;
      for (int i = 0; i < hw; i++)
        push(op, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 3'd4, 8'h00);
      push(op, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 3'd4, 8'h00);
      m_hlt = 1'b0;
    end else begin
      if (mem)
        for (int i = 0; i < ds; i++)
          push(op, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd1, den);
      push(op, d, mem ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'd1, den);
      if (is_load) m_dout = d;
      if (is_ill) m_ill = 1'b1;
      push(op, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'd2, (nib == 4'h1) ? E_ALUWR : 8'h00);
    end
    push(op, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 3'd3, E_PCEN | ((nib == 4'h7) ? E_RAMRD : 8'h00));
    m_ret = m_ret + 1'b1;
  endtask

  // Replays the trace: compare at the negedge, then drive that cycle's inputs
  task automatic run_q();
    logic [RW-1:0] ret0;
    logic [63:0]   act, exp;
    o_states = '0; o_ramrd = 0; o_aluwr = 0; o_pcen = 0; o_hlt = 0; o_pre = 0;
    ret0 = retired;
    foreach (q[i]) begin
      act = {31'b0, state, dut_en(), data_output, halted, illegal, retired};
      exp = {31'b0, q[i].st, q[i].en, q[i].dout, q[i].hlt, q[i].ill, q[i].ret};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL cycle instr=%0d step=%0d: got st=%0d en=%b dout=%h hlt=%b ill=%b ret=%0d, expected st=%0d en=%b dout=%h hlt=%b ill=%b ret=%0d",
                    n_instr, i, state, dut_en(), data_output, halted, illegal, retired,
                    q[i].st, q[i].en, q[i].dout, q[i].hlt, q[i].ill, q[i].ret);
      o_states = (o_states << 4) | {29'b0, state};
      if (ram_rd_en) o_ramrd++;
      if (alu_wr_en) o_aluwr++;
      if (pc_en) o_pcen++;
      if (halted) o_hlt++;
      if (retired == ret0) o_pre++;
      opcode    = q[i].op;
      data_bus  = q[i].db;
      mem_ready = q[i].mr;
      resume    = q[i].rs;
`ifdef SEQ_SINGLE_STEP_EN
      step      = q[i].stp;
`endif
      @(negedge clk);
    end
  endtask

  task automatic instr(input logic [DW-1:0] op, input logic [DW-1:0] d, input int fs,
                       input int ds, input int hw);
    build(op, d, fs, ds, hw);
    run_q();
    $display("instr %0d op=%h fetch_stall=%0d decode_stall=%0d halt_wait=%0d cycles=%0d retired=%0d",
             n_instr, op, fs, ds, hw, q.size(), retired);
    n_instr++;
  endtask

  logic [7:0] cl_tab[7] = '{8'h22, 8'h42, 8'h41, 8'h31, 8'h92, 8'h91, 8'h32};
  logic [3:0] nb_tab[3] = '{4'h1, 4'h7, 4'hF};

  initial begin
    logic [DW-1:0] op;
    int            r;
    reset = 1'b1; opcode = '0; data_bus = '0; mem_ready = 1'b0; resume = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    m_dout = '0; m_ill = 1'b0; m_hlt = 1'b0; m_ret = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {31'b0, state, dut_en(), data_output, halted, illegal, retired},
        {31'b0, 3'd0, 8'hC0, 16'h0000, 1'b0, 1'b0, 4'h0});
    reset = 1'b0;

    instr(16'h2205, 16'h00AB, 0, 0, 0);
    chk("2205_data_output", data_output, 16'h00AB);
    chk("2205_retired", retired, 4'd1);
    chk("2205_states", o_states, 32'h0000_0123);
    chk("2205_cycles", o_pre, 4);

    instr(16'h1003, 16'h0F0F, 0, 0, 0);
    chk("1003_alu_wr_cycles", o_aluwr, 1);
    chk("1003_pc_en_cycles", o_pcen, 1);

    instr(16'h4201, 16'h1234, 0, 3, 0);
    chk("4201_ram_rd_cycles", o_ramrd, 4);
    chk("4201_cycles", o_pre, 7);
    chk("4201_data_output", data_output, 16'h1234);

    instr(16'h0000, 16'h0000, 0, 0, 2);
    chk("halt_halted_cycles", o_hlt, 3);
    chk("halt_states", o_states, 32'h0001_4443);
    chk("halt_retired", retired, 4'd4);

    instr(16'h5500, 16'h5A5A, 0, 0, 0);
    chk("5500_illegal", illegal, 1'b1);
    chk("5500_data_hold", data_output, 16'h1234);
    chk("5500_pc_en_cycles", o_pcen, 1);

    instr(16'h7123, 16'h0001, 1, 0, 0);
    chk("7123_ram_rd_commit", o_ramrd, 1);
    chk("7123_illegal_sticky", illegal, 1'b1);

    // Asynchronous reset while stalled in DECODE
    opcode = 16'h4201; data_bus = 16'hBEEF; mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_reset_in_decode", state, 3'd1);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_reset", {31'b0, state, dut_en(), data_output, halted, illegal, retired},
           {31'b0, 3'd0, 8'hC0, 16'h0000, 1'b0, 1'b0, 4'h0});
    @(negedge clk);
    reset = 1'b0;
    m_dout = '0; m_ill = 1'b0; m_hlt = 1'b0; m_ret = '0;

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) op = {cl_tab[r], 8'($urandom)};
      else if (r == 7) op = '0;
      else if (r == 8) op = {nb_tab[$urandom_range(0, 2)], 12'($urandom)};
      else op = 16'($urandom);
      instr(op, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
